conv_seq_ctrl: RTL and testbench
================================

// Module: conv_seq_ctrl
// PURPOSE
//  Sequencer for the 3x3-kernel / 4x4-map / 2x2-output convolution PE block. Accepts one job per
//  valid/ready command, fetches 9 weights (optional) and 16 map pixels from a shared 1-cycle-latency
//  read memory into the PE staging registers, pulses weight_load/start, waits for done, and
//  returns the four 8-bit results on a valid/ready result port. Sits between the job host and the PE.
// PARAMETERS
//  DATA_W   8   pixel/weight/result width
//  ADDR_W   8   memory address width
//  TIMEOUT  64  max cycles in WAIT before error abort
// PORTS
//  clk            in   1         clock, all logic on rising edge
//  rst            in   1         asynchronous, active-low reset
//  cmd_valid      in   1         job request
//  cmd_ready      out  1         high only in IDLE
//  cmd_reload_w   in   1         1 = fetch + latch new weights; 0 = reuse current weights
//  cmd_w_base     in   ADDR_W    weight base address (9 words, row-major w_11..w_33)
//  cmd_in_base    in   ADDR_W    map base address (16 words, row-major in_11..in_44)
//  mem_req        out  1         read strobe
//  mem_addr       out  ADDR_W    read address
//  mem_rdata      in   DATA_W    read data, valid exactly 1 cycle after mem_req
//  stg_w_we       out  1         weight staging write enable
//  stg_in_we      out  1         map staging write enable
//  stg_idx        out  4         staging index (0..8 weights, 0..15 map), row-major
//  stg_data       out  DATA_W    staging write data (= mem_rdata)
//  pe_weight_load out  1         1-cycle pulse
//  pe_start       out  1         1-cycle pulse
//  pe_done        in   1         PE completion, sampled only in WAIT
//  pe_result      in   4*DATA_W  {out_22,out_21,out_12,out_11}
//  res_valid      out  1         result available
//  res_ready      in   1         result consumer ready
//  res_data       out  4*DATA_W  captured pe_result, stable while res_valid
//  busy           out  1         high in any state except IDLE
//  err_timeout    out  1         sticky; set on WAIT timeout, cleared on next accepted command
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready=1; counters 0; res_data 0.
//  States: IDLE, LOAD_W, LATCH_W, LOAD_IN, START, WAIT, OUT.
//  IDLE: accept when cmd_valid&&cmd_ready (cycle 0); latch cmd fields; next LOAD_W if reload_w else LOAD_IN.
//  LOAD_W: 10 cycles; issue mem_req at w_base+i for i=0..8 (cycles 1..9); stg_w_we with stg_idx=i
//   one cycle later (cycles 2..10). -> LATCH_W.
//  LATCH_W: 1 cycle, pe_weight_load=1. -> LOAD_IN.
//  LOAD_IN: 17 cycles; 16 issues at in_base+i, writes lag by one. -> START.
//  START: 1 cycle, pe_start=1. With reload: pe_start in cycle 29; without: cycle 18.
//  WAIT: capture pe_result into res_data on cycle pe_done=1 -> OUT. Counter starts 0 on entry;
//   if it reaches TIMEOUT without pe_done: set err_timeout, -> IDLE, no result issued.
//  OUT: res_valid=1 (first cycle after pe_done); hold res_data until res_valid&&res_ready -> IDLE.
//  Address arithmetic wraps modulo 2^ADDR_W (base 0xFC, i=5 -> 0x01).
//  pe_done outside WAIT ignored. cmd_valid while busy ignored (cmd_ready=0).
//  Command accept in IDLE clears err_timeout that same edge.
//  Reset mid-job: immediate return to IDLE, pulses/strobes drop asynchronously, staging writes abort.
// CONFIGURATION
//  CONV_SEQ_CTRL_PERF_EN defined: adds output perf_cycles[15:0] = cycles from accept to res_valid
//   (saturates at 0xFFFF), updated when entering OUT, held otherwise; reset 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package conv_pkg: K_TAPS=9, MAP_PIX=16, OUT_PIX=4, state encoding constants, result
//   lane ordering constants.
//  Sub-module conv_fetch_seq: base/count/start in, mem_req/mem_addr out, delayed we/idx out, done
//   pulse; instantiated once, reused for weight and map fetch phases.
// TESTING
//  1. reload_w=1, w_base=0x10, in_base=0x20, pe_done 3 cycles after pe_start, res_ready=1 ->
//     pe_weight_load cycle 11, pe_start cycle 29, 9+16 staging writes in order, one res_valid beat.
//  2. reload_w=0 -> no LOAD_W/pe_weight_load, pe_start cycle 18.
//  3. pe_done never asserted -> err_timeout=1 after 64 WAIT cycles, IDLE, no res_valid; next
//     accepted cmd clears err_timeout.
//  4. res_ready held low 5 cycles -> res_valid and res_data stable, cmd_ready=0 until handshake.
//  5. in_base=0xFC -> addresses 0xFC..0xFF then 0x00..0x0B.
//  6. rst low during LOAD_IN -> all outputs reset immediately; next job runs normally; spurious
//     pe_done in IDLE ignored.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 / 4x4 / 2x2 convolution sequencer.
package conv_pkg;

    // Kernel, input map and output map sizes
    localparam int K_TAPS  = 9;
    localparam int MAP_PIX = 16;
    localparam int OUT_PIX = 4;

    // Fetch counter width: holds the largest fetch count (MAP_PIX)
    localparam int CNT_W = 5;

    // Lane positions inside pe_result / res_data, each lane DATA_W bits wide
    localparam int LANE_11 = 0;
    localparam int LANE_12 = 1;
    localparam int LANE_21 = 2;
    localparam int LANE_22 = 3;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_LATCH_W = 3'd2,
        ST_LOAD_IN = 3'd3,
        ST_START   = 3'd4,
        ST_WAIT    = 3'd5,
        ST_OUT     = 3'd6
    } seq_state_t;

    // Saturating 16-bit increment, used by the optional cycle counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/conv_fetch_seq.sv
// Burst reader for the shared 1-cycle-latency memory. A start pulse loads the
// base address and word count; one read per cycle is issued from the next cycle
// on, and the matching staging write (index + enable) follows one cycle later.
// done pulses together with the last staging write.
module conv_fetch_seq
    import conv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              we,
    output logic [3:0]        idx,
    output logic              done
);

    logic              active;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] base_q;
    logic              last;
    logic              we_p1;
    logic              last_p1;
    logic [3:0]        idx_p1;

    assign last     = active && (cnt == count_q - CNT_W'(1));
    assign mem_req  = active;
    assign mem_addr = active ? base_q + ADDR_W'(cnt) : '0;
    assign we       = we_p1;
    assign idx      = we_p1 ? idx_p1 : 4'd0;
    assign done     = we_p1 && last_p1;

    // Issue counter and the one-cycle-delayed write strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            count_q <= '0;
            we_p1   <= 1'b0;
            last_p1 <= 1'b0;
            idx_p1  <= 4'd0;
        end else begin
            if (start) begin
                active  <= (count != '0);
                cnt     <= '0;
                count_q <= count;
            end else if (active) begin
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    active <= 1'b0;
                end
            end
            // read data returns one cycle after the request
            we_p1   <= active;
            last_p1 <= last;
            idx_p1  <= cnt[3:0];
        end
    end

    // Burst base address, captured with the start pulse
    always_ff @(posedge clk) begin
        if (start) begin
            base_q <= base;
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Job sequencer for the convolution PE: fetches weights (optional) and map pixels
// into the PE staging registers, pulses weight_load/start, waits for done with a
// timeout, and hands the four results out on a valid/ready port.
// Optional build macro CONV_SEQ_CTRL_PERF_EN adds perf_cycles (accept-to-result
// latency, saturating at 0xFFFF).
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_reload_w,
    input  logic [ADDR_W-1:0]         cmd_w_base,
    input  logic [ADDR_W-1:0]         cmd_in_base,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      stg_w_we,
    output logic                      stg_in_we,
    output logic [3:0]                stg_idx,
    output logic [DATA_W-1:0]         stg_data,
    output logic                      pe_weight_load,
    output logic                      pe_start,
    input  logic                      pe_done,
    input  logic [OUT_PIX*DATA_W-1:0] pe_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [OUT_PIX*DATA_W-1:0] res_data,
    output logic                      busy,
    output logic                      err_timeout
`ifdef CONV_SEQ_CTRL_PERF_EN
    ,
    output logic [15:0]               perf_cycles
`endif
);

    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              accept;
    logic              f_start;
    logic [ADDR_W-1:0] f_base;
    logic [CNT_W-1:0]  f_count;
    logic              f_we;
    logic              f_done;
    logic [ADDR_W-1:0] in_base_p0;
    logic [WC_W-1:0]   wait_cnt;
    logic              wait_expire;

    assign accept      = (state == ST_IDLE) && cmd_valid;
    assign wait_expire = (state == ST_WAIT) && !pe_done && (wait_cnt == WAIT_LAST);

    // The fetch engine is kicked at accept (weights or map) and again from
    // LATCH_W for the map burst that follows a weight reload.
    assign f_start = accept || (state == ST_LATCH_W);
    assign f_base  = accept ? (cmd_reload_w ? cmd_w_base : cmd_in_base) : in_base_p0;
    assign f_count = (accept && cmd_reload_w) ? CNT_W'(K_TAPS) : CNT_W'(MAP_PIX);

    conv_fetch_seq #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk      (clk),
        .rst      (rst),
        .start    (f_start),
        .base     (f_base),
        .count    (f_count),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .we       (f_we),
        .idx      (stg_idx),
        .done     (f_done)
    );

    assign stg_data = f_we ? mem_rdata : '0;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        state_nxt      = state;
        cmd_ready      = 1'b0;
        busy           = 1'b1;
        pe_weight_load = 1'b0;
        pe_start       = 1'b0;
        res_valid      = 1'b0;
        stg_w_we       = 1'b0;
        stg_in_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = cmd_reload_w ? ST_LOAD_W : ST_LOAD_IN;
                end
            end
            ST_LOAD_W: begin
                stg_w_we = f_we;
                if (f_done) begin
                    state_nxt = ST_LATCH_W;
                end
            end
            ST_LATCH_W: begin
                pe_weight_load = 1'b1;
                state_nxt      = ST_LOAD_IN;
            end
            ST_LOAD_IN: begin
                stg_in_we = f_we;
                if (f_done) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                pe_start  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (pe_done) begin
                    state_nxt = ST_OUT;
                end else if (wait_expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Map base is reused for the second burst of a reload job
    always_ff @(posedge clk) begin
        if (accept) begin
            in_base_p0 <= cmd_in_base;
        end
    end

    // WAIT dwell counter, cleared whenever the PE is not being waited on
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + WC_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Result capture and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_data    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if ((state == ST_WAIT) && pe_done) begin
                res_data <= pe_result;
            end
            if (accept) begin
                err_timeout <= 1'b0;
            end else if (wait_expire) begin
                err_timeout <= 1'b1;
            end
        end
    end

`ifdef CONV_SEQ_CTRL_PERF_EN
    logic [15:0] perf_cnt;

    // Accept-to-result latency; perf_cnt equals the cycle number within the job
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt    <= 16'd0;
            perf_cycles <= 16'd0;
        end else begin
            if (accept) begin
                perf_cnt <= 16'd1;
            end else if (busy) begin
                perf_cnt <= sat_inc16(perf_cnt);
            end
            if ((state == ST_WAIT) && pe_done) begin
                perf_cycles <= sat_inc16(perf_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: a memory model, a PE model that convolves
// whatever the sequencer staged, and queues of expected addresses, staging
// writes, pulse timings and results filled when each job is issued.
module tb_conv_seq_ctrl;
    import conv_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_reload_w;
    logic [7:0]  cmd_w_base, cmd_in_base;
    logic        mem_req;
    logic [7:0]  mem_addr, mem_rdata;
    logic        stg_w_we, stg_in_we;
    logic [3:0]  stg_idx;
    logic [7:0]  stg_data;
    logic        pe_weight_load, pe_start, pe_done;
    logic [31:0] pe_result;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        busy, err_timeout;

    conv_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_reload_w(cmd_reload_w), .cmd_w_base(cmd_w_base), .cmd_in_base(cmd_in_base),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .stg_w_we(stg_w_we), .stg_in_we(stg_in_we), .stg_idx(stg_idx), .stg_data(stg_data),
        .pe_weight_load(pe_weight_load), .pe_start(pe_start), .pe_done(pe_done),
        .pe_result(pe_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [7:0]  mem [0:255];
    logic [7:0]  model_w [0:8];
    logic [7:0]  addr_q [$];
    logic [13:0] stg_q [$];
    logic [31:0] res_q [$];
    int          start_q [$];
    int          wl_q [$];
    int          rv_q [$];

    int   pe_dly = 0;
    int   hold_n = 0;
    logic spur = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference 3x3 valid convolution, lanes packed {out_22,out_21,out_12,out_11}
    function automatic logic [31:0] conv_ref(input logic [7:0] w [0:8], input logic [7:0] x [0:15]);
        logic [31:0] r;
        logic [7:0]  acc;
        r = '0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                acc = 8'd0;
                for (int k = 0; k < 9; k++) begin
                    acc = acc + 8'(w[k] * x[(k / 3 + dr) * 4 + (k % 3 + dc)]);
                end
                r[(dr * 2 + dc) * 8 +: 8] = acc;
            end
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Shared memory: data one cycle after the request
    always @(posedge clk) mem_rdata <= mem_req ? mem[mem_addr] : 8'h00;

    // PE model: staging registers, weight latch, delayed done with the convolution
    initial begin
        logic [7:0]  pe_w  [0:8];
        logic [7:0]  pe_wa [0:8];
        logic [7:0]  pe_in [0:15];
        logic [31:0] acc_res;
        bit pend;
        int ctr;
        logic nd;
        pend = 0; ctr = 0;
        for (int i = 0; i < 9; i++) begin pe_w[i] = 8'h00; pe_wa[i] = 8'h00; end
        for (int i = 0; i < 16; i++) pe_in[i] = 8'h00;
        pe_done = 1'b0;
        pe_result = 32'h0;
        forever begin
            @(negedge clk);
            if (stg_w_we && stg_idx < 4'd9) pe_w[int'(stg_idx)] = stg_data;
            if (stg_in_we) pe_in[int'(stg_idx)] = stg_data;
            if (pe_weight_load) pe_wa = pe_w;
            nd = spur;
            pe_result = $urandom;
            if (pend) begin
                ctr++;
                if (ctr == pe_dly) begin
                    acc_res = conv_ref(pe_wa, pe_in);
                    nd = 1'b1;
                    pe_result = acc_res;
                    pend = 0;
                end
            end
            if (pe_start && pe_dly != 0) begin
                pend = 1;
                ctr = 0;
            end
            if (!rst) pend = 0;
            pe_done = nd;
        end
    end

    // Monitor: read addresses, staging writes, pulse timing
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_req) begin
                    if (addr_q.size() > 0) check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
                    else check("mem_req_extra", 64'(1), 64'(0));
                end
                if (stg_w_we || stg_in_we) begin
                    if (stg_q.size() > 0)
                        check("stg_write", 64'({stg_w_we, stg_in_we, stg_idx, stg_data}), 64'(stg_q.pop_front()));
                    else check("stg_write_extra", 64'(1), 64'(0));
                end
                if (pe_weight_load) begin
                    if (wl_q.size() > 0) check("weight_load_cycle", 64'(cyc - acc_cyc), 64'(wl_q.pop_front()));
                    else check("weight_load_extra", 64'(1), 64'(0));
                end
                if (pe_start) begin
                    if (start_q.size() > 0) check("pe_start_cycle", 64'(cyc - acc_cyc), 64'(start_q.pop_front()));
                    else check("pe_start_extra", 64'(1), 64'(0));
                end
            end
        end
    end

    // Result consumer: optional back-pressure, stability and data checks
    initial begin
        bit rv_seen;
        int hold_ctr;
        logic [31:0] hold_first;
        rv_seen = 0; hold_ctr = 0; hold_first = '0;
        res_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && res_valid) begin
                if (!rv_seen) begin
                    rv_seen = 1;
                    hold_first = res_data;
                    if (rv_q.size() > 0) check("res_valid_cycle", 64'(cyc - acc_cyc), 64'(rv_q.pop_front()));
                    else check("res_valid_unexpected", 64'(1), 64'(0));
                end else begin
                    check("res_data_stable", 64'(res_data), 64'(hold_first));
                end
                if (hold_ctr < hold_n) begin
                    check("cmd_ready_during_out", 64'(cmd_ready), 64'(0));
                    hold_ctr++;
                    res_ready = 1'b0;
                end else begin
                    res_ready = 1'b1;
                    if (res_q.size() > 0) check("res_data", 64'(res_data), 64'(res_q.pop_front()));
                    else check("res_extra", 64'(1), 64'(0));
                    rv_seen = 0;
                    hold_ctr = 0;
                end
            end
        end
    end

    // Issue one job from a negedge in IDLE, filling the scoreboard first
    task automatic send_job(input bit rl, input logic [7:0] wb, input logic [7:0] ib,
                            input int dly, input int hold);
        logic [7:0] a;
        logic [7:0] xin [0:15];
        int s;
        if (rl) begin
            for (int i = 0; i < 9; i++) begin
                a = wb + 8'(i);
                model_w[i] = mem[a];
                addr_q.push_back(a);
                stg_q.push_back({2'b10, 4'(i), mem[a]});
            end
        end
        for (int i = 0; i < 16; i++) begin
            a = ib + 8'(i);
            xin[i] = mem[a];
            addr_q.push_back(a);
            stg_q.push_back({2'b01, 4'(i), mem[a]});
        end
        s = rl ? 29 : 18;
        if (rl) wl_q.push_back(11);
        start_q.push_back(s);
        if (dly > 0) begin
            res_q.push_back(conv_ref(model_w, xin));
            rv_q.push_back(s + dly + 1);
        end
        pe_dly = dly;
        hold_n = hold;
        res_ready = (hold == 0);
        cmd_reload_w = rl;
        cmd_w_base = wb;
        cmd_in_base = ib;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        acc_cyc = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("err_clear_on_accept", 64'(err_timeout), 64'(0));
        check("busy_after_accept", 64'(busy), 64'(1));
    endtask

    // Bounded wait for IDLE, then job length and drained scoreboard
    task automatic wait_idle(input int exp_len);
        for (int n = 0; n < 400; n++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (busy) check("idle_wait_expired", 64'(1), 64'(0));
        else check("job_length", 64'(cyc - acc_cyc), 64'(exp_len));
        check("scoreboard_drained", 64'(addr_q.size() + stg_q.size() + res_q.size()
              + start_q.size() + wl_q.size() + rv_q.size()), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        for (int i = 0; i < 9; i++) model_w[i] = 8'h00;
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_reload_w = 1'b0; cmd_w_base = 8'h00; cmd_in_base = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_data", 64'(res_data), 64'(0));
        check("rst_err", 64'(err_timeout), 64'(0));
        check("rst_pe_start", 64'(pe_start), 64'(0));
        check("rst_stg_we", 64'({stg_w_we, stg_in_we}), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // reload, PE done 3 cycles after start
        send_job(1'b1, 8'h10, 8'h20, 3, 0);
        wait_idle(29 + 3 + 2);
        // reuse weights
        send_job(1'b0, 8'h00, 8'h40, 2, 0);
        wait_idle(18 + 2 + 2);
        // PE never finishes
        send_job(1'b0, 8'h00, 8'h30, 0, 0);
        wait_idle(18 + 65);
        check("err_timeout_set", 64'(err_timeout), 64'(1));
        // back-pressure on the result port; clears err_timeout on accept
        send_job(1'b1, 8'h80, 8'h90, 4, 5);
        wait_idle(29 + 4 + 1 + 5 + 1);
        // map base wraps through 0xFF
        send_job(1'b0, 8'h00, 8'hFC, 1, 0);
        wait_idle(18 + 1 + 2);

        // reset in the middle of LOAD_IN
        send_job(1'b1, 8'h50, 8'h60, 3, 0);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_mem_req", 64'(mem_req), 64'(0));
        check("abort_stg_in_we", 64'(stg_in_we), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        addr_q.delete(); stg_q.delete(); res_q.delete();
        start_q.delete(); wl_q.delete(); rv_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("spurious_done_busy", 64'(busy), 64'(0));
        check("spurious_done_res_valid", 64'(res_valid), 64'(0));
        @(negedge clk);
        check("spurious_done_idle", 64'({busy, res_valid, cmd_ready}), 64'(1));
        send_job(1'b1, 8'hA0, 8'hB0, 3, 0);
        wait_idle(29 + 3 + 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
